// File: rtl/mem_stage.sv
// Memory stage of the pipeline: forwards ALU results and runs load/store
// handshakes with the data memory (ack-or-timeout) before writeback.

package mem_stage_pkg;
    localparam int OPCODE_WIDTH = 8;
    localparam int REG_WIDTH    = 16;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [REG_WIDTH-1:0]    reg_t;

    localparam opcode_t OP_ADD = 8'h10;
    localparam opcode_t OP_SUB = 8'h11;
    localparam opcode_t OP_AND = 8'h12;
    localparam opcode_t OP_LDB = 8'h40;
    localparam opcode_t OP_LDW = 8'h41;
    localparam opcode_t OP_STB = 8'h42;
    localparam opcode_t OP_STW = 8'h43;

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LDB) || (op == OP_LDW) || (op == OP_STB) || (op == OP_STW);
    endfunction

    function automatic logic is_store_op(input opcode_t op);
        return (op == OP_STB) || (op == OP_STW);
    endfunction

    function automatic logic is_byte_op(input opcode_t op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction
endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    I_CLOCK,
    input  logic                    I_RESET_N,
    input  logic                    I_LOCK,
    input  logic                    I_EX_Valid,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [3:0]              I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]    I_DestValue,
    input  logic [REG_WIDTH-1:0]    I_MARValue,
    input  logic [REG_WIDTH-1:0]    I_MDRValue,
    input  logic                    I_RegWEn,
    output logic                    O_DMemReq,
    output logic                    O_DMemWE,
    output logic                    O_DMemByte,
    output logic [REG_WIDTH-1:0]    O_DMemAddr,
    output logic [REG_WIDTH-1:0]    O_DMemWData,
    input  logic                    I_DMemAck,
    input  logic [REG_WIDTH-1:0]    I_DMemRData,
    output logic                    O_MEMStallSignal,
    output logic                    O_MemErr,
    output logic                    O_MEM_Valid,
    output logic [OPCODE_WIDTH-1:0] O_Opcode,
    output logic [3:0]              O_DestRegIdx,
    output logic [REG_WIDTH-1:0]    O_DestValue,
    output logic                    O_RegWEn
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e        state_q;
    logic [7:0]    wait_cnt_q;
    logic [7:0]    wait_cnt_d;
    logic          dmem_req_q;
    logic          dmem_we_q;
    logic          dmem_byte_q;
    reg_t          dmem_addr_q;
    reg_t          dmem_wdata_q;
    logic          mem_err_q;
    logic          mem_valid_q;
    opcode_t       opcode_q;
    logic [3:0]    dest_idx_q;
    reg_t          dest_value_q;
    logic          reg_wen_q;

    logic          accept;
    logic          mem_op;
    logic          misaligned;
    logic          timeout;
    reg_t          load_value;

    assign accept     = (state_q == S_IDLE) && I_LOCK && I_EX_Valid;
    assign mem_op     = is_mem_op(I_Opcode);
    assign misaligned = mem_op && !is_byte_op(I_Opcode) && I_MARValue[0];
    assign wait_cnt_d = wait_cnt_q + 8'd1;
    assign timeout    = (wait_cnt_d == 8'hFF);

    always_comb begin
        // NOTE: assign a default before any branch so no latch is inferred.
        load_value = I_DMemRData;
        if (is_byte_op(opcode_q)) begin
            load_value = {{(REG_WIDTH-8){1'b0}}, I_DMemRData[7:0]};
        end
    end

    // Falling-edge clocking matches the rest of the pipeline.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(negedge I_CLOCK) begin
        if (!I_RESET_N) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_byte_q  <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            mem_err_q    <= 1'b0;
            mem_valid_q  <= 1'b0;
            opcode_q     <= '0;
            dest_idx_q   <= '0;
            dest_value_q <= '0;
            reg_wen_q    <= 1'b0;
        end else begin
            mem_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    wait_cnt_q <= '0;
                    if (!accept) begin
                        mem_valid_q <= 1'b0;
                        reg_wen_q   <= 1'b0;
                    end else if (!mem_op) begin
                        mem_valid_q  <= 1'b1;
                        opcode_q     <= I_Opcode;
                        dest_idx_q   <= I_DestRegIdx;
                        dest_value_q <= I_DestValue;
                        reg_wen_q    <= I_RegWEn;
                    end else if (misaligned) begin
                        mem_err_q   <= 1'b1;
                        mem_valid_q <= 1'b0;
                        reg_wen_q   <= 1'b0;
                    end else begin
                        state_q      <= S_WAIT;
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= is_store_op(I_Opcode);
                        dmem_byte_q  <= is_byte_op(I_Opcode);
                        dmem_addr_q  <= I_MARValue;
                        dmem_wdata_q <= I_MDRValue;
                        opcode_q     <= I_Opcode;
                        dest_idx_q   <= I_DestRegIdx;
                        mem_valid_q  <= 1'b0;
                        reg_wen_q    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Ack wins over a timeout landing on the same edge.
                    if (I_DMemAck) begin
                        state_q     <= S_IDLE;
                        dmem_req_q  <= 1'b0;
                        mem_valid_q <= 1'b1;
                        if (dmem_we_q) begin
                            reg_wen_q <= 1'b0;
                        end else begin
                            reg_wen_q    <= 1'b1;
                            dest_value_q <= load_value;
                        end
                    end else if (timeout) begin
                        state_q     <= S_IDLE;
                        wait_cnt_q  <= wait_cnt_d;
                        dmem_req_q  <= 1'b0;
                        mem_err_q   <= 1'b1;
                        mem_valid_q <= 1'b0;
                        reg_wen_q   <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign O_MEMStallSignal = (state_q == S_WAIT);
    assign O_DMemReq        = dmem_req_q;
    assign O_DMemWE         = dmem_we_q;
    assign O_DMemByte       = dmem_byte_q;
    assign O_DMemAddr       = dmem_addr_q;
    assign O_DMemWData      = dmem_wdata_q;
    assign O_MemErr         = mem_err_q;
    assign O_MEM_Valid      = mem_valid_q;
    assign O_Opcode         = opcode_q;
    assign O_DestRegIdx     = dest_idx_q;
    assign O_DestValue      = dest_value_q;
    assign O_RegWEn         = reg_wen_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, multi-cycle handshake
// sequences and randomized transactions against a transaction-level model.

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       ex_valid;
    opcode_t    opcode;
    logic [3:0] dest_idx;
    reg_t       dest_value;
    reg_t       mar;
    reg_t       mdr;
    logic       reg_wen;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_byte;
    reg_t       dmem_addr;
    reg_t       dmem_wdata;
    logic       dmem_ack;
    reg_t       dmem_rdata;
    logic       stall;
    logic       mem_err;
    logic       mem_valid;
    opcode_t    o_opcode;
    logic [3:0] o_dest_idx;
    reg_t       o_dest_value;
    logic       o_reg_wen;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .I_CLOCK          (clk),
        .I_RESET_N        (rst_n),
        .I_LOCK           (lock),
        .I_EX_Valid       (ex_valid),
        .I_Opcode         (opcode),
        .I_DestRegIdx     (dest_idx),
        .I_DestValue      (dest_value),
        .I_MARValue       (mar),
        .I_MDRValue       (mdr),
        .I_RegWEn         (reg_wen),
        .O_DMemReq        (dmem_req),
        .O_DMemWE         (dmem_we),
        .O_DMemByte       (dmem_byte),
        .O_DMemAddr       (dmem_addr),
        .O_DMemWData      (dmem_wdata),
        .I_DMemAck        (dmem_ack),
        .I_DMemRData      (dmem_rdata),
        .O_MEMStallSignal (stall),
        .O_MemErr         (mem_err),
        .O_MEM_Valid      (mem_valid),
        .O_Opcode         (o_opcode),
        .O_DestRegIdx     (o_dest_idx),
        .O_DestValue      (o_dest_value),
        .O_RegWEn         (o_reg_wen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Active edge is the falling one; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input opcode_t op, input logic [3:0] idx, input reg_t dv,
                         input reg_t a, input reg_t d, input logic rwe,
                         input logic lk, input logic ev);
        opcode     = op;
        dest_idx   = idx;
        dest_value = dv;
        mar        = a;
        mdr        = d;
        reg_wen    = rwe;
        lock       = lk;
        ex_valid   = ev;
    endtask

    // Reference classification, written from the opcode list directly.
    function automatic bit m_is_load(input opcode_t op);
        return op inside {OP_LDB, OP_LDW};
    endfunction
    function automatic bit m_is_store(input opcode_t op);
        return op inside {OP_STB, OP_STW};
    endfunction
    function automatic bit m_is_byte(input opcode_t op);
        return op inside {OP_LDB, OP_STB};
    endfunction
    function automatic bit m_misaligned(input opcode_t op, input reg_t a);
        return (op inside {OP_LDW, OP_STW}) && (a % 2 == 1);
    endfunction
    function automatic reg_t m_load_result(input opcode_t op, input reg_t rd);
        return (op == OP_LDB) ? reg_t'(rd % 256) : rd;
    endfunction

    typedef struct {
        opcode_t    op;
        logic [3:0] idx;
        reg_t       dv;
        reg_t       mar;
        logic       rwe;
        logic       lock;
        logic       exv;
        logic       ack;
        logic       e_valid;
        logic       e_rwe;
        logic       e_err;
    } vec_t;

    vec_t vecs[9];
    opcode_t op_pool[7];

    initial begin
        int   lat;
        int   stall_cnt;
        bit   acc;
        reg_t rd;

        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive(OP_ADD, 4'h0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst_req",   dmem_req, 0);
        check("rst_valid", mem_valid, 0);
        check("rst_rwe",   o_reg_wen, 0);
        check("rst_err",   mem_err, 0);
        check("rst_stall", stall, 0);
        check("rst_dv",    o_dest_value, 0);
        check("rst_idx",   o_dest_idx, 0);
        check("rst_op",    o_opcode, 0);
        check("rst_addr",  dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        rst_n = 1'b1;

        // Single-edge vectors: none of these starts a memory transaction.
        vecs[0] = '{OP_ADD, 4'h3, 16'h0012, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{OP_AND, 4'h7, 16'hABCD, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{OP_LDW, 4'h2, 16'h1111, 16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{OP_STW, 4'h1, 16'h0000, 16'h0043, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{OP_LDW, 4'h5, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{OP_ADD, 4'h9, 16'h2222, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{OP_SUB, 4'h4, 16'h3333, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{OP_LDB, 4'h6, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{OP_SUB, 4'hF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].op, vecs[i].idx, vecs[i].dv, vecs[i].mar, 16'h7777,
                  vecs[i].rwe, vecs[i].lock, vecs[i].exv);
            dmem_ack = vecs[i].ack;
            step();
            check($sformatf("vec%0d_valid", i), mem_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_rwe", i), o_reg_wen, vecs[i].e_rwe);
            check($sformatf("vec%0d_err", i), mem_err, vecs[i].e_err);
            check($sformatf("vec%0d_req", i), dmem_req, 0);
            check($sformatf("vec%0d_stall", i), stall, 0);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_dv", i), o_dest_value, vecs[i].dv);
                check($sformatf("vec%0d_idx", i), o_dest_idx, vecs[i].idx);
                check($sformatf("vec%0d_op", i), o_opcode, vecs[i].op);
            end
        end
        dmem_ack = 1'b0;
        drive(OP_ADD, 4'h0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        step();
        check("err_one_edge", mem_err, 0);

        // LDW with ack on the third WAIT edge.
        drive(OP_LDW, 4'h8, 16'h0000, 16'h0040, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        stall_cnt = 0;
        check("ldw_req", dmem_req, 1);
        check("ldw_we", dmem_we, 0);
        check("ldw_addr", dmem_addr, 16'h0040);
        for (int k = 1; k <= 3; k++) begin
            if (stall) stall_cnt++;
            dmem_ack   = (k == 3);
            dmem_rdata = (k == 3) ? 16'hBEEF : 16'h0BAD;
            step();
        end
        dmem_ack = 1'b0;
        check("ldw_stall_edges", stall_cnt, 3);
        check("ldw_stall_end", stall, 0);
        check("ldw_dv", o_dest_value, 16'hBEEF);
        check("ldw_rwe", o_reg_wen, 1);
        check("ldw_valid", mem_valid, 1);
        check("ldw_idx", o_dest_idx, 4'h8);
        check("ldw_req_drop", dmem_req, 0);

        // LDB from an odd address is legal and zero-extends.
        drive(OP_LDB, 4'h2, 16'h0000, 16'h0041, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        check("ldb_byte", dmem_byte, 1);
        check("ldb_req", dmem_req, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h12AB;
        step();
        dmem_ack = 1'b0;
        check("ldb_dv", o_dest_value, 16'h00AB);
        check("ldb_valid", mem_valid, 1);

        // STW aligned.
        drive(OP_STW, 4'h1, 16'h0000, 16'h0044, 16'h5A5A, 1'b1, 1'b1, 1'b1);
        step();
        check("stw_we", dmem_we, 1);
        check("stw_byte", dmem_byte, 0);
        check("stw_wdata", dmem_wdata, 16'h5A5A);
        check("stw_addr", dmem_addr, 16'h0044);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("stw_rwe", o_reg_wen, 0);
        check("stw_valid", mem_valid, 1);

        // Timeout: LDW with no ack.
        drive(OP_LDW, 4'h3, 16'h0000, 16'h0080, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        stall_cnt = 0;
        while (stall && stall_cnt < 400) begin
            stall_cnt++;
            step();
        end
        check("to_stall_edges", stall_cnt, 255);
        check("to_err", mem_err, 1);
        check("to_valid", mem_valid, 0);
        check("to_rwe", o_reg_wen, 0);
        check("to_req", dmem_req, 0);
        ex_valid = 1'b0;
        step();
        check("to_err_pulse", mem_err, 0);

        // Reset during WAIT, then a late ack.
        drive(OP_LDW, 4'h4, 16'h0000, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        check("rw_req", dmem_req, 1);
        step();
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        ex_valid = 1'b0;
        check("rw_req_clr", dmem_req, 0);
        check("rw_stall_clr", stall, 0);
        step();
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hDEAD;
        step();
        dmem_ack = 1'b0;
        check("rw_late_valid", mem_valid, 0);
        check("rw_late_req", dmem_req, 0);
        check("rw_late_stall", stall, 0);

        // Randomized transactions.
        op_pool[0] = OP_ADD; op_pool[1] = OP_SUB; op_pool[2] = OP_AND;
        op_pool[3] = OP_LDB; op_pool[4] = OP_LDW; op_pool[5] = OP_STB; op_pool[6] = OP_STW;
        for (int t = 0; t < 300; t++) begin
            drive(op_pool[$urandom_range(6)], 4'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 1'($urandom), ($urandom_range(9) != 0), ($urandom_range(7) != 0));
            acc = lock && ex_valid;
            step();
            check("r_err", mem_err, acc && m_misaligned(opcode, mar));
            if (!acc || m_misaligned(opcode, mar)) begin
                check("r_idle_valid", mem_valid, 0);
                check("r_idle_rwe", o_reg_wen, 0);
                check("r_idle_req", dmem_req, 0);
                check("r_idle_stall", stall, 0);
            end else if (!(m_is_load(opcode) || m_is_store(opcode))) begin
                check("r_alu_valid", mem_valid, 1);
                check("r_alu_dv", o_dest_value, dest_value);
                check("r_alu_rwe", o_reg_wen, reg_wen);
                check("r_alu_req", dmem_req, 0);
            end else begin
                check("r_mem_req", dmem_req, 1);
                check("r_mem_we", dmem_we, m_is_store(opcode));
                check("r_mem_byte", dmem_byte, m_is_byte(opcode));
                check("r_mem_addr", dmem_addr, mar);
                check("r_mem_wdata", dmem_wdata, mdr);
                check("r_mem_valid", mem_valid, 0);
                lat = $urandom_range(1, 6);
                rd  = '0;
                for (int k = 1; k <= lat; k++) begin
                    check("r_wait_stall", stall, 1);
                    lock       = 1'($urandom);
                    dmem_ack   = (k == lat);
                    dmem_rdata = 16'($urandom);
                    rd         = dmem_rdata;
                    step();
                    if (k < lat) begin
                        check("r_wait_req", dmem_req, 1);
                        check("r_wait_addr", dmem_addr, mar);
                    end
                end
                dmem_ack = 1'b0;
                check("r_done_stall", stall, 0);
                check("r_done_valid", mem_valid, 1);
                check("r_done_req", dmem_req, 0);
                check("r_done_rwe", o_reg_wen, m_is_load(opcode));
                if (m_is_load(opcode)) check("r_done_dv", o_dest_value, m_load_result(opcode, rd));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
